i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter data_size, default 8: width of rx_data and tx_data.
REQ-002 Parameter sync_stages, default 2: number of synchronizer flops on scl_in and sda_in.
REQ-003 Port core_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port enable, input, 1: 1 means the block answers its address; 0 forces IDLE.
REQ-006 Port own_address, input, 7: the 7-bit target address.
REQ-007 Port scl_in, input, 1: raw bus SCL, asynchronous to core_clk.
REQ-008 Port sda_in, input, 1: raw bus SDA, asynchronous to core_clk.
REQ-009 Port sda_out, output, 1: open-drain drive; 0 pulls SDA low, 1 releases it.
REQ-010 Port rx_data, output, data_size: last byte written by the controller.
REQ-011 Port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-012 Port rx_ready, input, 1: 1 means a received byte is ACKed; 0 means it is NACKed.
REQ-013 Port tx_data, input, data_size: byte returned to the controller on a read.
REQ-014 Port tx_req, output, 1: one-cycle pulse when tx_data is captured.
REQ-015 Port busy, output, 1: high from the address match until STOP or loss of selection.
REQ-016 Port stop_det, output, 1: one-cycle pulse on each detected STOP.

Function
REQ-017 scl_in and sda_in SHALL pass through sync_stages flops plus one history flop; every event below uses the synchronized values.
- Detection latency from the bus edge is sync_stages+1 cycles.
REQ-018 Event definitions on synchronized signals:
- START = SDA falls while SCL is high.
- STOP = SDA rises while SCL is high.
- Data is sampled on the SCL rise.
- sda_out changes only in the cycle an SCL fall is detected.
REQ-019 States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-020 A START in any state, including a repeated START, SHALL:
- go to ADDR;
- clear the bit counter;
- release sda_out.
REQ-021 A STOP in any state SHALL:
- go to IDLE;
- release sda_out;
- drop busy;
- pulse stop_det.
REQ-022 ADDR shifts 8 bits, MSB first. After the 8th SCL rise:
- if bits[7:1]==own_address and enable=1: go to ADDR_ACK and set busy;
- otherwise: go to WAIT_STOP.
REQ-023 ADDR_ACK drives sda_out=0 from the next SCL fall until the following SCL fall. At that second fall:
- R/W=0: go to RX_BYTE and release SDA;
- R/W=1: capture tx_data, pulse tx_req, drive its MSB, go to TX_BYTE.
REQ-024 RX_BYTE samples 8 bits. On the 8th SCL rise, rx_data is updated and rx_valid pulses in the same cycle. Then RX_ACK:
- if rx_ready=1 at that cycle: drive 0 for the 9th bit, then return to RX_BYTE;
- otherwise: keep SDA released (NACK), then WAIT_STOP.
REQ-025 TX_BYTE shifts the next bit onto sda_out at each SCL fall. After the 8th bit it releases SDA and enters TX_ACK.
REQ-026 TX_ACK samples SDA on the 9th SCL rise:
- 0 (ACK): at the next SCL fall, capture tx_data, pulse tx_req, go to TX_BYTE;
- 1 (NACK): release SDA, go to WAIT_STOP.
REQ-027 WAIT_STOP keeps SDA released and ignores data bits until START or STOP.
REQ-028 enable=0 SHALL force IDLE on the next cycle:
- sda_out=1, busy=0;
- no rx_valid or tx_req pulses.
REQ-029 The bit counter is 4 bits and counts 0..8 per byte, resetting on every START and every byte boundary. A START and a STOP cannot both be seen in one cycle; START has priority.
REQ-030 There is no clock stretching; SCL is never driven.

Reset
REQ-031 With rst_n=0, asynchronously:
- state=IDLE; sda_out=1;
- rx_data=0; rx_valid=0; tx_req=0; busy=0; stop_det=0;
- shift register and bit counter = 0;
- synchronizer flops = 1 (idle bus).
REQ-032 After reset release, no START is detected until a real SDA fall occurs with SCL high.

Structure
REQ-033 Shared package i2c_pkg holds:
- the state enumeration;
- ADDR_WIDTH=7;
- ACK=1'b0 and NACK=1'b1.
REQ-034 One sub-module, i2c_line_sync: the synchronizer and edge detector. It outputs scl, sda, scl_rise, scl_fall, start_det and stop_det_raw.

Verification
REQ-035 Write: own_address=7'h50, controller writes 8'hA0 then 8'h3C with rx_ready=1 -> address ACK, rx_valid twice with rx_data=8'h3C last, both bytes ACKed, stop_det pulses, busy=0.
REQ-036 Mismatch: controller addresses 7'h51 -> SDA never driven low, busy stays 0, no rx_valid, state WAIT_STOP until STOP.
REQ-037 Read: address 8'hA1 with tx_data=8'h96 then 8'h5A; controller ACKs the first byte and NACKs the second -> bus carries 96,5A; tx_req pulses twice; WAIT_STOP until STOP.
REQ-038 Back-pressure: rx_ready=0 when byte 8'h11 completes -> rx_valid pulses, 9th bit NACKed, following bytes ignored.
REQ-039 Repeated START after a write byte, then read address 8'hA1 -> re-ACK, tx_req pulses, tx_data shifted out.
REQ-040 rst_n asserted mid-TX_BYTE while driving a 0 -> sda_out=1 immediately, all outputs at reset values, next START handled normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus constants.
package i2c_pkg;

    localparam int unsigned ADDR_WIDTH = 7;
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA into core_clk and derives edge, START and STOP events.
module i2c_line_sync #(
    parameter int unsigned sync_stages = 2
) (
    input  logic core_clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det_raw
);

    logic [sync_stages-1:0] scl_sync;
    logic [sync_stages-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    // Reset to the idle-bus level so no edge is seen on reset release.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync[0] <= scl_in;
            sda_sync[0] <= sda_in;
            for (int unsigned i = 1; i < sync_stages; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_d <= scl;
            sda_d <= sda;
        end
    end

    assign scl          = scl_sync[sync_stages-1];
    assign sda          = sda_sync[sync_stages-1];
    assign scl_rise     = scl & ~scl_d;
    assign scl_fall     = ~scl & scl_d;
    assign start_det    = scl & scl_d & sda_d & ~sda;
    assign stop_det_raw = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte receive with rx_ready ACK control, byte transmit.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int unsigned data_size   = 8,
    parameter int unsigned sync_stages = 2
) (
    input  logic                 core_clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [6:0]           own_address,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 sda_out,
    output logic [data_size-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic [data_size-1:0] tx_data,
    output logic                 tx_req,
    output logic                 busy,
    output logic                 stop_det
);

    logic scl_unused, sda, scl_rise, scl_fall, start_det, stop_det_raw;

    i2c_line_sync #(.sync_stages(sync_stages)) u_line_sync (
        .core_clk    (core_clk),
        .rst_n       (rst_n),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .scl         (scl_unused),
        .sda         (sda),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_det   (start_det),
        .stop_det_raw(stop_det_raw)
    );

    state_t               state, state_nx;
    logic [3:0]           bit_cnt, bit_cnt_nx;
    // Holds the earlier bits of a byte; the final bit is taken straight from sda.
    logic [data_size-2:0] shift_reg, shift_nx;
    logic [data_size-1:0] tx_shift, tx_shift_nx;
    logic [data_size-1:0] rx_data_nx;
    logic sda_out_nx, busy_nx, rx_valid_nx, tx_req_nx, stop_det_nx;
    logic rw, rw_nx, ack_flag, ack_nx, phase, phase_nx, load_tx;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_shift  <= '0;
            sda_out   <= 1'b1;
            busy      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            stop_det  <= 1'b0;
            rw        <= 1'b0;
            ack_flag  <= ACK;
            phase     <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            shift_reg <= shift_nx;
            tx_shift  <= tx_shift_nx;
            sda_out   <= sda_out_nx;
            busy      <= busy_nx;
            rx_data   <= rx_data_nx;
            rx_valid  <= rx_valid_nx;
            tx_req    <= tx_req_nx;
            stop_det  <= stop_det_nx;
            rw        <= rw_nx;
            ack_flag  <= ack_nx;
            phase     <= phase_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        shift_nx    = shift_reg;
        tx_shift_nx = tx_shift;
        sda_out_nx  = sda_out;
        busy_nx     = busy;
        rx_data_nx  = rx_data;
        rw_nx       = rw;
        ack_nx      = ack_flag;
        phase_nx    = phase;
        rx_valid_nx = 1'b0;
        tx_req_nx   = 1'b0;
        stop_det_nx = stop_det_raw;
        load_tx     = 1'b0;

        if (!enable) begin
            state_nx   = IDLE;
            sda_out_nx = NACK;
            busy_nx    = 1'b0;
            bit_cnt_nx = '0;
            phase_nx   = 1'b0;
        end else if (start_det) begin
            state_nx   = ADDR;
            bit_cnt_nx = '0;
            sda_out_nx = NACK;
            phase_nx   = 1'b0;
        end else if (stop_det_raw) begin
            state_nx   = IDLE;
            sda_out_nx = NACK;
            busy_nx    = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_nx   = {shift_reg[data_size-3:0], sda};
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        if (shift_reg[ADDR_WIDTH-1:0] == own_address) begin
                            state_nx = ADDR_ACK;
                            busy_nx  = 1'b1;
                            rw_nx    = sda;
                            phase_nx = 1'b0;
                        end else begin
                            state_nx = WAIT_STOP;
                            busy_nx  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_out_nx = ACK;
                        phase_nx   = 1'b1;
                    end else if (!rw) begin
                        state_nx   = RX_BYTE;
                        sda_out_nx = NACK;
                        bit_cnt_nx = '0;
                        phase_nx   = 1'b0;
                    end else begin
                        load_tx = 1'b1;
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_nx   = {shift_reg[data_size-3:0], sda};
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(data_size - 1)) begin
                        rx_data_nx  = {shift_reg, sda};
                        rx_valid_nx = 1'b1;
                        ack_nx      = rx_ready ? ACK : NACK;
                        phase_nx    = 1'b0;
                        state_nx    = RX_ACK;
                    end
                end
                RX_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_out_nx = ack_flag;
                        phase_nx   = 1'b1;
                    end else begin
                        sda_out_nx = NACK;
                        phase_nx   = 1'b0;
                        bit_cnt_nx = '0;
                        state_nx   = (ack_flag == ACK) ? RX_BYTE : WAIT_STOP;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(data_size - 1)) begin
                        sda_out_nx = NACK;
                        phase_nx   = 1'b0;
                        state_nx   = TX_ACK;
                    end else begin
                        sda_out_nx  = tx_shift[data_size-1];
                        tx_shift_nx = tx_shift << 1;
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda == ACK) phase_nx = 1'b1;
                        else            state_nx = WAIT_STOP;
                    end else if (scl_fall && phase) begin
                        load_tx = 1'b1;
                    end
                end
                WAIT_STOP: sda_out_nx = NACK;
                default: ;
            endcase
        end

        // MSB goes out immediately; the remaining bits leave from tx_shift on later falls.
        if (load_tx) begin
            tx_shift_nx = tx_data << 1;
            sda_out_nx  = tx_data[data_size-1];
            tx_req_nx   = 1'b1;
            state_nx    = TX_BYTE;
            bit_cnt_nx  = '0;
            phase_nx    = 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on a wired-AND SDA line.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       core_clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] own_address;
    logic       scl_m, sda_m, sda_bus;
    logic       sda_out;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_req, busy, stop_det;

    int checks = 0;
    int errors = 0;
    int rx_valid_cnt = 0, tx_req_cnt = 0, stop_cnt = 0, low_cnt = 0;

    assign sda_bus = sda_m & sda_out;

    i2c_target #(.data_size(8), .sync_stages(2)) dut (
        .core_clk   (core_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .own_address(own_address),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_out    (sda_out),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .busy       (busy),
        .stop_det   (stop_det)
    );

    always #5 core_clk = ~core_clk;

    always @(negedge core_clk) begin
        if (rx_valid) rx_valid_cnt <= rx_valid_cnt + 1;
        if (tx_req)   tx_req_cnt   <= tx_req_cnt + 1;
        if (stop_det) stop_cnt     <= stop_cnt + 1;
        if (!sda_out) low_cnt      <= low_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (Q) @(negedge core_clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; half();
        scl_m = 1'b1; half();
        sda_m = 1'b0; half();
        scl_m = 1'b0; half();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; half();
        scl_m = 1'b1; half();
        sda_m = 1'b1; half();
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b; half();
        scl_m = 1'b1; half();
        s = sda_bus; half();
        scl_m = 1'b0; half();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int rv0, tr0, sp0, lo0;

        rst_n = 1'b0; enable = 1'b1; own_address = 7'h50;
        scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b1; tx_data = 8'h00;
        repeat (3) @(negedge core_clk);
        chk("rst_sda_out",  32'(sda_out),   32'h1);
        chk("rst_rx_data",  32'(rx_data),   32'h0);
        chk("rst_rx_valid", 32'(rx_valid),  32'h0);
        chk("rst_tx_req",   32'(tx_req),    32'h0);
        chk("rst_busy",     32'(busy),      32'h0);
        chk("rst_stop_det", 32'(stop_det),  32'h0);
        chk("rst_state",    32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        half();
        chk("post_rst_idle", 32'(dut.state), 32'(IDLE));

        // Write: address 0x50, data A0 then 3C
        rv0 = rx_valid_cnt; sp0 = stop_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        chk("wr_addr_ack", 32'(ack), 32'h0);
        chk("wr_busy", 32'(busy), 32'h1);
        write_byte(8'hA0, ack);
        chk("wr_d0_ack", 32'(ack), 32'h0);
        chk("wr_d0_rx_data", 32'(rx_data), 32'hA0);
        write_byte(8'h3C, ack);
        chk("wr_d1_ack", 32'(ack), 32'h0);
        chk("wr_rx_data", 32'(rx_data), 32'h3C);
        chk("wr_rx_valid_cnt", 32'(rx_valid_cnt - rv0), 32'd2);
        bus_stop();
        half();
        chk("wr_stop_cnt", 32'(stop_cnt - sp0), 32'd1);
        chk("wr_busy_after", 32'(busy), 32'h0);
        chk("wr_state_after", 32'(dut.state), 32'(IDLE));

        // Mismatch: address 0x51
        rv0 = rx_valid_cnt; lo0 = low_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        chk("mm_addr_nack", 32'(ack), 32'h1);
        chk("mm_state", 32'(dut.state), 32'(WAIT_STOP));
        write_byte(8'h77, ack);
        chk("mm_data_nack", 32'(ack), 32'h1);
        chk("mm_busy", 32'(busy), 32'h0);
        chk("mm_no_low", 32'(low_cnt - lo0), 32'd0);
        chk("mm_no_rx_valid", 32'(rx_valid_cnt - rv0), 32'd0);
        chk("mm_state_wait", 32'(dut.state), 32'(WAIT_STOP));
        bus_stop();
        half();
        chk("mm_state_idle", 32'(dut.state), 32'(IDLE));

        // Read: 96 (ACKed) then 5A (NACKed)
        tr0 = tx_req_cnt;
        tx_data = 8'h96;
        bus_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", 32'(ack), 32'h0);
        tx_data = 8'h5A;
        read_byte(1'b0, rd);
        chk("rd_byte0", 32'(rd), 32'h96);
        read_byte(1'b1, rd);
        chk("rd_byte1", 32'(rd), 32'h5A);
        chk("rd_tx_req_cnt", 32'(tx_req_cnt - tr0), 32'd2);
        chk("rd_state_wait", 32'(dut.state), 32'(WAIT_STOP));
        bus_stop();
        half();
        chk("rd_busy_after", 32'(busy), 32'h0);

        // Back-pressure: 11 NACKed, next byte ignored
        bus_start();
        write_byte(8'hA0, ack);
        chk("bp_addr_ack", 32'(ack), 32'h0);
        rv0 = rx_valid_cnt;
        rx_ready = 1'b0;
        write_byte(8'h11, ack);
        chk("bp_nack", 32'(ack), 32'h1);
        chk("bp_rx_data", 32'(rx_data), 32'h11);
        chk("bp_rx_valid_cnt", 32'(rx_valid_cnt - rv0), 32'd1);
        chk("bp_state", 32'(dut.state), 32'(WAIT_STOP));
        rx_ready = 1'b1;
        write_byte(8'h22, ack);
        chk("bp_ignored_nack", 32'(ack), 32'h1);
        chk("bp_ignored_data", 32'(rx_data), 32'h11);
        chk("bp_ignored_valid", 32'(rx_valid_cnt - rv0), 32'd1);
        bus_stop();

        // Repeated START: write 55, then read C3
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h55, ack);
        chk("rs_wr_ack", 32'(ack), 32'h0);
        tr0 = tx_req_cnt;
        tx_data = 8'hC3;
        bus_start();
        write_byte(8'hA1, ack);
        chk("rs_addr_ack", 32'(ack), 32'h0);
        chk("rs_busy", 32'(busy), 32'h1);
        read_byte(1'b1, rd);
        chk("rs_read", 32'(rd), 32'hC3);
        chk("rs_tx_req_cnt", 32'(tx_req_cnt - tr0), 32'd1);
        bus_stop();

        // enable dropped while selected
        bus_start();
        write_byte(8'hA0, ack);
        rv0 = rx_valid_cnt;
        enable = 1'b0;
        repeat (2) @(negedge core_clk);
        chk("en_busy", 32'(busy), 32'h0);
        chk("en_state", 32'(dut.state), 32'(IDLE));
        write_byte(8'h33, ack);
        chk("en_nack", 32'(ack), 32'h1);
        chk("en_no_rx_valid", 32'(rx_valid_cnt - rv0), 32'd0);
        enable = 1'b1;
        bus_stop();

        // Reset while driving a 0 in TX_BYTE
        tx_data = 8'h0F;
        bus_start();
        write_byte(8'hA1, ack);
        chk("rr_state_tx", 32'(dut.state), 32'(TX_BYTE));
        chk("rr_drive_low", 32'(sda_out), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rr_sda_rel", 32'(sda_out), 32'h1);
        chk("rr_busy", 32'(busy), 32'h0);
        chk("rr_rx_data", 32'(rx_data), 32'h0);
        chk("rr_state", 32'(dut.state), 32'(IDLE));
        repeat (2) @(negedge core_clk);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (2) @(negedge core_clk);
        rst_n = 1'b1;
        half();
        chk("rr_no_false_start", 32'(dut.state), 32'(IDLE));
        bus_start();
        write_byte(8'hA0, ack);
        chk("rr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h77, ack);
        chk("rr_rx_data_new", 32'(rx_data), 32'h77);
        bus_stop();
        half();
        chk("rr_busy_end", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
